rr_poll_scheduler: RTL

- Shares one downstream consumer port among N_PORTS passive producers that use the req/ack handshake of the async_operator fabric.
- Polls producers round-robin: raises req_l to one producer at a time and waits up to TIMEOUT cycles for its single-cycle ack.
- On ack, captures the data word and source id, then offers them downstream on req_r/ack_r.
- Sits between several producer-side operator outputs (or testbench producers) and one consumer/out operator.

---
 rtl/rr_poll_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rr_poll_scheduler.sv
// Round-robin poller that shares one downstream consumer among N_PORTS
// passive producers speaking the req/ack handshake. One producer is asked
// at a time; a captured word is held until the consumer takes it.
module rr_poll_scheduler #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [N_PORTS-1:0]            req_l,
  input  logic [N_PORTS-1:0]            ack_l,
  input  logic [DATA_WIDTH*N_PORTS-1:0] din,
  input  logic                          req_r,
  output logic                          ack_r,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic [31:0]                   count,
  output logic                          err
);

  // state | meaning
  // IDLE  | just out of reset, start polling at ptr on the next cycle
  // POLL  | req_l[ptr] high, waiting up to TIMEOUT cycles for ack_l[ptr]
  // GAP   | one req-free cycle after a timeout; a late ack from old is still taken
  // HOLD  | captured word parked on dout until the consumer requests it

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POLL = 2'd1,
    GAP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                state, state_d;
  logic [ID_WIDTH-1:0]   ptr, ptr_d;
  logic [ID_WIDTH-1:0]   old, old_d;
  logic [TW-1:0]         timer, timer_d;
  logic [N_PORTS-1:0]    req_l_d;
  logic                  ack_r_d;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [ID_WIDTH-1:0]   grant_d;
  logic [31:0]           count_d;
  logic                  err_d;
  logic [N_PORTS-1:0]    exp_mask;
  logic [DATA_WIDTH-1:0] din_ptr;
  logic [DATA_WIDTH-1:0] din_old;

  function automatic logic [N_PORTS-1:0] onehot(input logic [ID_WIDTH-1:0] p);
    logic [N_PORTS-1:0] r;
    r = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (p == ID_WIDTH'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [ID_WIDTH-1:0] next_port(input logic [ID_WIDTH-1:0] p);
    if (p == ID_WIDTH'(N_PORTS - 1)) return '0;
    return p + ID_WIDTH'(1);
  endfunction

  // Select the data slices of the currently polled port and the port left behind by a timeout.
  always_comb begin
    din_ptr = '0;
    din_old = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (ptr == ID_WIDTH'(i)) din_ptr = din[DATA_WIDTH*i +: DATA_WIDTH];
      if (old == ID_WIDTH'(i)) din_old = din[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  // Next-state and next-output logic; req_l and ack_r are computed here and registered below.
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    old_d    = old;
    timer_d  = timer;
    req_l_d  = '0;
    ack_r_d  = 1'b0;
    dout_d   = dout;
    grant_d  = grant_id;
    count_d  = count;
    exp_mask = '0;

    case (state)
      IDLE: begin
        state_d = POLL;
        timer_d = '0;
        req_l_d = onehot(ptr);
      end
      POLL: begin
        exp_mask = onehot(ptr);
        // capture wins over a timeout landing on the same cycle
        if (|(ack_l & onehot(ptr))) begin
          dout_d  = din_ptr;
          grant_d = ptr;
          state_d = HOLD;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          old_d   = ptr;
          ptr_d   = next_port(ptr);
          state_d = GAP;
        end else begin
          timer_d = timer + TW'(1);
          req_l_d = onehot(ptr);
        end
      end
      GAP: begin
        // the producer may have sampled req on the last POLL edge and answers now
        exp_mask = onehot(old);
        if (|(ack_l & onehot(old))) begin
          dout_d  = din_old;
          grant_d = old;
          ptr_d   = old;
          state_d = HOLD;
        end else begin
          timer_d = '0;
          req_l_d = onehot(ptr);
          state_d = POLL;
        end
      end
      HOLD: begin
        if (req_r && !ack_r) begin
          ack_r_d = 1'b1;
          count_d = count + 32'd1;
          ptr_d   = next_port(grant_id);
          timer_d = '0;
          req_l_d = onehot(next_port(grant_id));
          state_d = POLL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    err_d = err | (|(ack_l & ~exp_mask));
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      old      <= '0;
      timer    <= '0;
      req_l    <= '0;
      ack_r    <= 1'b0;
      dout     <= '0;
      grant_id <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      old      <= old_d;
      timer    <= timer_d;
      req_l    <= req_l_d;
      ack_r    <= ack_r_d;
      dout     <= dout_d;
      grant_id <= grant_d;
      count    <= count_d;
      err      <= err_d;
    end
  end

endmodule
